seq_detect_param: RTL and testbench

- Parametrised serial bit-pattern detector: a generalised successor to the team's fixed "101" Mealy detector.
- Pattern and don't-care mask are run-time loadable; overlapping or non-overlapping detection is selectable.
- Counts matches in a saturating counter; bits are qualified by a valid strobe.
- Sits on serial bit-streams (framing/sync-word search) ahead of deserialisers.

---
 rtl/seq_detect_param_if.sv | 28 ++
 rtl/seq_detect_param.sv | 113 +++++++++++
 tb/tb_seq_detect_param.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - bit-stream, pattern-load and match-report bundle for seq_detect_param
interface seq_detect_param_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [PAT_W-1:0] mask_in;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             hist_full;

  // Stream source / configuration side
  modport master (
    output en, x, overlap, pat_load, pat_in, mask_in, cnt_clr,
    input  y, match_cnt, hist_full
  );

  // Detector side
  modport slave (
    input  en, x, overlap, pat_load, pat_in, mask_in, cnt_clr,
    output y, match_cnt, hist_full
  );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - loadable masked serial pattern detector with saturating match counter (option: SEQ_DETECT_REGOUT_EN)
module seq_detect_param #(
  parameter int               PAT_W   = 3,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b101)
) (
  input logic                clk,
  input logic                rst,
  seq_detect_param_if.slave  bus
);

  localparam int             FW   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FW-1:0]  FULL = FW'(PAT_W - 1);

  // EMPTY: no valid history, FILLING: partial history, ARMED: a match can be decided
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q;
  logic [PAT_W-1:0]   mask_q;
  logic [PAT_W-2:0]   hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PAT_W-1:0]   window;
  logic               hit;

  // Oldest history bit lines up with the pattern MSB, the live bit with its LSB
  assign window = {hist_q, bus.x};
  assign hit    = bus.en & ~bus.pat_load & (state_q == ARMED)
                & (((window ^ pat_q) & mask_q) == '0);

  // Pattern and mask registers, reloaded on request
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      mask_q <= '1;
    end else if (bus.pat_load) begin
      pat_q  <= bus.pat_in;
      mask_q <= bus.mask_in;
    end
  end

  // History/fill state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  // Next history: a load or a non-overlapping hit restarts collection, other valid bits shift in
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (bus.pat_load) begin
      state_d = EMPTY;
      hist_d  = '0;
      fill_d  = '0;
    end else if (bus.en) begin
      if (hit && !bus.overlap) begin
        state_d = EMPTY;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        hist_d  = window[PAT_W-2:0];
        fill_d  = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        state_d = (fill_d == FULL) ? ARMED : FILLING;
      end
    end
  end

  // Match counter: clear wins over a same-cycle hit, saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
  assign bus.hist_full = (state_q == ARMED);

`ifdef SEQ_DETECT_REGOUT_EN
  logic y_q;

  // Registered match pulse, one clock after the matching bit
  always_ff @(posedge clk) begin
    if (rst || bus.pat_load) begin
      y_q <= 1'b0;
    end else begin
      y_q <= hit;
    end
  end

  assign bus.y = y_q;
`else
  assign bus.y = hit;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param
module tb_seq_detect_param;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, x, overlap, pat_load, cnt_clr;
  logic [PW-1:0] pat_in, mask_in;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detect_param_if #(.PAT_W(PW), .CNT_W(8)) bus8 ();
  seq_detect_param_if #(.PAT_W(PW), .CNT_W(2)) bus2 ();

  assign bus8.en = en;       assign bus2.en = en;
  assign bus8.x = x;         assign bus2.x = x;
  assign bus8.overlap = overlap;   assign bus2.overlap = overlap;
  assign bus8.pat_load = pat_load; assign bus2.pat_load = pat_load;
  assign bus8.pat_in = pat_in;     assign bus2.pat_in = pat_in;
  assign bus8.mask_in = mask_in;   assign bus2.mask_in = mask_in;
  assign bus8.cnt_clr = cnt_clr;   assign bus2.cnt_clr = cnt_clr;

  seq_detect_param #(.PAT_W(PW), .CNT_W(8), .PAT_RST(3'b101)) dut (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  seq_detect_param #(.PAT_W(PW), .CNT_W(2), .PAT_RST(3'b101)) dut_s (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Behavioural model: list of bits seen since the last restart, pattern, counts
  logic          hq[$];
  logic [PW-1:0] m_pat  = 3'b101;
  logic [PW-1:0] m_mask = 3'b111;
  int            m_cnt8 = 0;
  int            m_cnt2 = 0;
  logic          m_yreg = 1'b0;
  logic          e_hit, e_y;

  function automatic logic m_hit();
    int base;
    logic b;
    if (!en || pat_load || hq.size() < PW-1) return 1'b0;
    base = hq.size() - (PW-1);
    for (int i = 0; i < PW; i++) begin
      b = (i < PW-1) ? hq[base+i] : x;
      if (m_mask[PW-1-i] && (b != m_pat[PW-1-i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input logic h);
    if (rst) begin
      hq.delete();
      m_pat = 3'b101; m_mask = 3'b111;
      m_cnt8 = 0; m_cnt2 = 0; m_yreg = 1'b0;
    end else begin
      m_yreg = h;
      if (cnt_clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (h) begin
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
      if (pat_load) begin
        m_pat = pat_in; m_mask = mask_in; hq.delete();
      end else if (en) begin
        if (h && !overlap) hq.delete();
        else begin
          hq.push_back(x);
          if (hq.size() > PW-1) void'(hq.pop_front());
        end
      end
    end
  endtask

  // Compare every cycle mid-period, then advance the model across the coming edge
  always @(negedge clk) begin
    e_hit = m_hit();
`ifdef SEQ_DETECT_REGOUT_EN
    e_y = m_yreg;
`else
    e_y = e_hit;
`endif
    chk("y8", bus8.y, e_y);
    chk("cnt8", bus8.match_cnt, m_cnt8);
    chk("full8", bus8.hist_full, hq.size() == PW-1);
    chk("y2", bus2.y, e_y);
    chk("cnt2", bus2.match_cnt, m_cnt2);
    chk("full2", bus2.hist_full, hq.size() == PW-1);
    model_step(e_hit);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid bit; check the same-cycle y literal, then clock it in
  task automatic vbit(input logic xx, input logic ey, input string nm);
    en = 1'b1; x = xx;
    #2;
`ifndef SEQ_DETECT_REGOUT_EN
    chk(nm, bus8.y, ey);
`endif
    tick();
  endtask

  task automatic do_rst();
    rst = 1'b1; en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b1; pat_load = 1'b0;
    cnt_clr = 1'b0; pat_in = '0; mask_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_cnt", bus8.match_cnt, 0);
    chk("rst_full", bus8.hist_full, 0);
    chk("rst_y", bus8.y, 0);

    // Overlapping: 1,0,1,0,1 -> hits on bits 3 and 5
    overlap = 1'b1;
    vbit(1, 0, "ov_b1");
    vbit(0, 0, "ov_b2");
    chk("ov_full_b2", bus8.hist_full, 1);
    vbit(1, 1, "ov_b3");
    vbit(0, 0, "ov_b4");
    vbit(1, 1, "ov_b5");
    chk("ov_cnt", bus8.match_cnt, 2);

    // Non-overlapping: same stream, one hit, history restarts
    do_rst();
    overlap = 1'b0;
    vbit(1, 0, "no_b1");
    vbit(0, 0, "no_b2");
    vbit(1, 1, "no_b3");
    chk("no_full_b3", bus8.hist_full, 0);
    vbit(0, 0, "no_b4");
    vbit(1, 0, "no_b5");
    chk("no_cnt", bus8.match_cnt, 1);

    // Pattern load discards the load-cycle bit
    pat_load = 1'b1; pat_in = 3'b110; mask_in = 3'b111; en = 1'b1; x = 1'b1;
    #2 chk("ld_y", bus8.y, 0);
    tick();
    pat_load = 1'b0;
    vbit(1, 0, "ld_b1");
    vbit(1, 0, "ld_b2");
    vbit(0, 1, "ld_b3");
    pat_load = 1'b1; pat_in = 3'b110; mask_in = 3'b101; x = 1'b0;
    tick();
    pat_load = 1'b0;
    vbit(1, 0, "mk_b1");
    vbit(0, 0, "mk_b2");
    vbit(0, 1, "mk_b3");

    // Idle gaps are transparent
    pat_load = 1'b1; pat_in = 3'b101; mask_in = 3'b111; x = 1'b0;
    tick();
    pat_load = 1'b0;
    vbit(1, 0, "gap_b1");
    for (int i = 0; i < 3; i++) begin
      en = 1'b0; x = i[0];
      #2 chk("gap_idle_y", bus8.y, 0);
      tick();
    end
    vbit(0, 0, "gap_b2");
    vbit(1, 1, "gap_b3");

    // Saturation on the 2-bit counter, then clear against a hit
    do_rst();
    overlap = 1'b1;
    for (int i = 0; i < 9; i++) vbit(~i[0], (i >= 2) && !i[0], "sat_bit");
    chk("sat_cnt2", bus2.match_cnt, 3);
    chk("sat_cnt8", bus8.match_cnt, 4);
    vbit(0, 0, "clr_b0");
    cnt_clr = 1'b1;
    vbit(1, 1, "clr_hit");
    cnt_clr = 1'b0;
    chk("clr_cnt8", bus8.match_cnt, 0);
    chk("clr_cnt2", bus2.match_cnt, 0);

    // Reset mid-stream loses history
    vbit(1, 0, "mr_b1");
    vbit(0, 0, "mr_b2");
    do_rst();
    vbit(1, 0, "mr_after");
    do_rst();
    vbit(1, 0, "mr_c1");
    vbit(0, 0, "mr_c2");
`ifdef SEQ_DETECT_REGOUT_EN
    en = 1'b1; x = 1'b1;
    #2 chk("reg_b3_y", bus8.y, 0);
    tick();
    en = 1'b0;
    chk("reg_pulse", bus8.y, 1);
    tick();
    chk("reg_drop", bus8.y, 0);
`else
    vbit(1, 1, "mr_c3");
    en = 1'b0;
`endif

    // Mixed tail: random bits, gaps, overlap changes, loads incl. mask=0
    for (int i = 0; i < 120; i++) begin
      en       = ($urandom_range(0, 4) != 0);
      x        = $urandom_range(0, 1);
      overlap  = $urandom_range(0, 1);
      cnt_clr  = ($urandom_range(0, 29) == 0);
      pat_load = ($urandom_range(0, 24) == 0);
      pat_in   = PW'($urandom_range(0, 7));
      mask_in  = (i > 60) ? PW'($urandom_range(0, 7)) : 3'b111;
      tick();
    end
    pat_load = 1'b1; pat_in = 3'b000; mask_in = 3'b000;
    tick();
    pat_load = 1'b0; cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; x = $urandom_range(0, 1); overlap = 1'b1;
      tick();
    end
    en = 1'b0;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
